// File: rtl/color_blob_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | color_blob_tracker                                                       |
// | Multi-channel HSV blob tracker: per-frame count, centroid and bbox.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module color_blob_tracker #(
    parameter int NCH             = 2,
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480,
    parameter int ACC_W           = 32,
    parameter int NOISE_THRESHOLD = 1024,
    parameter int NOT_FOUND       = 2023
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic                 i_valid,
    input  logic                 i_frame_end,
    input  logic [9:0]           i_h,
    input  logic [9:0]           i_s,
    input  logic [9:0]           i_v,
    input  logic [10:0]          i_x,
    input  logic [10:0]          i_y,
    input  logic [NCH*10-1:0]    i_hmin,
    input  logic [NCH*10-1:0]    i_hmax,
    input  logic [NCH*10-1:0]    i_smin,
    input  logic [NCH*10-1:0]    i_smax,
    input  logic [NCH*10-1:0]    i_vmin,
    input  logic [NCH*10-1:0]    i_vmax,
    output logic [NCH-1:0]       o_match,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic [NCH-1:0]       o_found,
    output logic [NCH*ACC_W-1:0] o_cnt,
    output logic [NCH*11-1:0]    o_cx,
    output logic [NCH*11-1:0]    o_cy,
    output logic [NCH*11-1:0]    o_xmin,
    output logic [NCH*11-1:0]    o_xmax,
    output logic [NCH*11-1:0]    o_ymin,
    output logic [NCH*11-1:0]    o_ymax
);
    localparam int NDIV = NCH * 2;
    localparam int IW   = (NDIV > 1) ? $clog2(NDIV) : 1;
    localparam int BW   = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [10:0]      WIDTH_C  = 11'(WIDTH);
    localparam logic [10:0]      HEIGHT_C = 11'(HEIGHT);
    localparam logic [10:0]      NF       = 11'(NOT_FOUND);
    localparam logic [IW-1:0]    IDX_LAST = IW'(NDIV - 1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(ACC_W - 1);
    localparam logic [ACC_W-1:0] THRESH   = ACC_W'(NOISE_THRESHOLD);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] sumx_q [NCH];
    logic [ACC_W-1:0] sumy_q [NCH];
    logic [ACC_W-1:0] cnt_q  [NCH];
    logic [10:0]      xmin_q [NCH];
    logic [10:0]      xmax_q [NCH];
    logic [10:0]      ymin_q [NCH];
    logic [10:0]      ymax_q [NCH];

    logic [IW-1:0]    idx_q;
    logic [BW-1:0]    bit_q;
    logic [ACC_W-1:0] rem_q, rem_d;
    logic [ACC_W-1:0] dq_q, dq_d;
    logic [10:0]      quot_q [NDIV];
    logic [10:0]      q_all  [NDIV];

    logic [NCH-1:0]   found_q;
    logic [ACC_W-1:0] res_cnt_q  [NCH];
    logic [10:0]      res_cx_q   [NCH];
    logic [10:0]      res_cy_q   [NCH];
    logic [10:0]      res_xmin_q [NCH];
    logic [10:0]      res_xmax_q [NCH];
    logic [10:0]      res_ymin_q [NCH];
    logic [10:0]      res_ymax_q [NCH];

    logic             in_bounds;
    assign in_bounds = (i_x < WIDTH_C) && (i_y < HEIGHT_C);

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_ch
            logic [9:0] hmin, hmax;
            logic       h_ok;
            assign hmin = i_hmin[10*c +: 10];
            assign hmax = i_hmax[10*c +: 10];
            // A reversed hue window wraps through 0/360.
            assign h_ok = (hmin <= hmax) ? ((i_h >= hmin) && (i_h <= hmax))
                                         : ((i_h >= hmin) || (i_h <= hmax));
            assign o_match[c] = in_bounds && h_ok
                             && (i_s >= i_smin[10*c +: 10]) && (i_s <= i_smax[10*c +: 10])
                             && (i_v >= i_vmin[10*c +: 10]) && (i_v <= i_vmax[10*c +: 10]);

            assign o_cnt[c*ACC_W +: ACC_W] = res_cnt_q[c];
            assign o_cx[c*11 +: 11]        = res_cx_q[c];
            assign o_cy[c*11 +: 11]        = res_cy_q[c];
            assign o_xmin[c*11 +: 11]      = res_xmin_q[c];
            assign o_xmax[c*11 +: 11]      = res_xmax_q[c];
            assign o_ymin[c*11 +: 11]      = res_ymin_q[c];
            assign o_ymax[c*11 +: 11]      = res_ymax_q[c];
        end
    endgenerate

    assign o_found = found_q;
    assign o_busy  = (state_q == S_ACC) || (state_q == S_DIV);
    assign o_valid = (state_q == S_OUT);

    logic             last_bit, last_div;
    logic [ACC_W-1:0] divisor, div_src, dvd, rem_in;
    logic [ACC_W:0]   sh;
    logic             ge;
    logic [10:0]      quot_fin;

    assign last_bit = (bit_q == BIT_LAST);
    assign last_div = last_bit && (idx_q == IDX_LAST);

    // Restoring divider; bit 0 of each division loads the dividend directly
    // so every quotient takes exactly ACC_W cycles.
    always_comb begin
        divisor = '0;
        div_src = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx_q == IW'(2*k)) begin
                divisor = cnt_q[k];
                div_src = sumx_q[k];
            end
            if (idx_q == IW'(2*k + 1)) begin
                divisor = cnt_q[k];
                div_src = sumy_q[k];
            end
        end
        dvd      = (bit_q == '0) ? div_src : dq_q;
        rem_in   = (bit_q == '0) ? '0 : rem_q;
        sh       = {rem_in, dvd[ACC_W-1]};
        ge       = (sh >= {1'b0, divisor});
        rem_d    = ge ? ACC_W'(sh - {1'b0, divisor}) : sh[ACC_W-1:0];
        dq_d     = {dvd[ACC_W-2:0], ge};
        quot_fin = (divisor == '0) ? 11'd0 : dq_d[10:0];
        for (int k = 0; k < NDIV; k++) begin
            q_all[k] = (idx_q == IW'(k)) ? quot_fin : quot_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start)     state_d = S_ACC;
            S_ACC:   if (i_frame_end) state_d = S_DIV;
            S_DIV:   if (last_div)    state_d = S_OUT;
            default:                  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            bit_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            found_q <= '0;
            for (int k = 0; k < NDIV; k++) quot_q[k] <= '0;
            for (int k = 0; k < NCH; k++) begin
                sumx_q[k]     <= '0;
                sumy_q[k]     <= '0;
                cnt_q[k]      <= '0;
                xmin_q[k]     <= 11'h7FF;
                xmax_q[k]     <= '0;
                ymin_q[k]     <= 11'h7FF;
                ymax_q[k]     <= '0;
                res_cnt_q[k]  <= '0;
                res_cx_q[k]   <= NF;
                res_cy_q[k]   <= NF;
                res_xmin_q[k] <= NF;
                res_xmax_q[k] <= NF;
                res_ymin_q[k] <= NF;
                res_ymax_q[k] <= NF;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        idx_q <= '0;
                        bit_q <= '0;
                        for (int k = 0; k < NCH; k++) begin
                            sumx_q[k] <= '0;
                            sumy_q[k] <= '0;
                            cnt_q[k]  <= '0;
                            xmin_q[k] <= 11'h7FF;
                            xmax_q[k] <= '0;
                            ymin_q[k] <= 11'h7FF;
                            ymax_q[k] <= '0;
                        end
                    end
                end
                S_ACC: begin
                    for (int k = 0; k < NCH; k++) begin
                        if (i_valid && o_match[k]) begin
                            sumx_q[k] <= sumx_q[k] + ACC_W'(i_x);
                            sumy_q[k] <= sumy_q[k] + ACC_W'(i_y);
                            cnt_q[k]  <= cnt_q[k] + ACC_W'(1);
                            if (i_x < xmin_q[k]) xmin_q[k] <= i_x;
                            if (i_x > xmax_q[k]) xmax_q[k] <= i_x;
                            if (i_y < ymin_q[k]) ymin_q[k] <= i_y;
                            if (i_y > ymax_q[k]) ymax_q[k] <= i_y;
                        end
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    dq_q  <= dq_d;
                    if (last_bit) begin
                        bit_q <= '0;
                        idx_q <= idx_q + IW'(1);
                        for (int k = 0; k < NDIV; k++) quot_q[k] <= q_all[k];
                    end else begin
                        bit_q <= bit_q + BW'(1);
                    end
                    if (last_div) begin
                        for (int k = 0; k < NCH; k++) begin
                            found_q[k]   <= (cnt_q[k] > THRESH);
                            res_cnt_q[k] <= cnt_q[k];
                            if (cnt_q[k] > THRESH) begin
                                res_cx_q[k]   <= q_all[2*k];
                                res_cy_q[k]   <= q_all[2*k + 1];
                                res_xmin_q[k] <= xmin_q[k];
                                res_xmax_q[k] <= xmax_q[k];
                                res_ymin_q[k] <= ymin_q[k];
                                res_ymax_q[k] <= ymax_q[k];
                            end else begin
                                res_cx_q[k]   <= NF;
                                res_cy_q[k]   <= NF;
                                res_xmin_q[k] <= NF;
                                res_xmax_q[k] <= NF;
                                res_ymin_q[k] <= NF;
                                res_ymax_q[k] <= NF;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_color_blob_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_color_blob_tracker                                                    |
// | Directed self-checking bench for color_blob_tracker (NCH=2, ACC_W=32).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_color_blob_tracker;
    localparam int NCH   = 2;
    localparam int ACC_W = 32;
    localparam int NF    = 2023;

    logic               clk;
    logic               rst_n;
    logic               start, valid, fend;
    logic [9:0]         h, s, v;
    logic [10:0]        x, y;
    logic [NCH*10-1:0]  hmin, hmax, smin, smax, vmin, vmax;
    logic [NCH-1:0]     match;
    logic               busy, ovalid;
    logic [NCH-1:0]     found;
    logic [NCH*ACC_W-1:0] cnt;
    logic [NCH*11-1:0]  cx, cy, xmin, xmax, ymin, ymax;

    int checks = 0;
    int errors = 0;

    color_blob_tracker dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_valid(valid),
        .i_frame_end(fend), .i_h(h), .i_s(s), .i_v(v), .i_x(x), .i_y(y),
        .i_hmin(hmin), .i_hmax(hmax), .i_smin(smin), .i_smax(smax),
        .i_vmin(vmin), .i_vmax(vmax), .o_match(match), .o_busy(busy),
        .o_valid(ovalid), .o_found(found), .o_cnt(cnt), .o_cx(cx), .o_cy(cy),
        .o_xmin(xmin), .o_xmax(xmax), .o_ymin(ymin), .o_ymax(ymax)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_win(input int ch, input int hl, input int hh, input int sl,
                           input int sh, input int vl, input int vh);
        hmin[ch*10 +: 10] = 10'(hl);
        hmax[ch*10 +: 10] = 10'(hh);
        smin[ch*10 +: 10] = 10'(sl);
        smax[ch*10 +: 10] = 10'(sh);
        vmin[ch*10 +: 10] = 10'(vl);
        vmax[ch*10 +: 10] = 10'(vh);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pix(input int hv, input int px, input int py, input bit fe);
        valid = 1'b1;
        h     = 10'(hv);
        x     = 11'(px);
        y     = 11'(py);
        fend  = fe;
        tick();
        valid = 1'b0;
        fend  = 1'b0;
    endtask

    task automatic send_square(input int x0, input int y0, input int w, input int ht,
                               input bit fe_last);
        for (int yy = y0; yy < y0 + ht; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                send_pix(120, xx, yy, fe_last && (yy == y0 + ht - 1) && (xx == x0 + w - 1));
    endtask

    // Returns the number of edges after the frame-end edge until o_valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (ovalid !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check("valid_timeout", 64'(n < 400), 64'd1);
    endtask

    task automatic check_ch(input string tag, input int ch, input int f, input int c,
                            input int ecx, input int ecy, input int exl, input int exh,
                            input int eyl, input int eyh);
        check($sformatf("%s_found%0d", tag, ch), 64'(found[ch]), 64'(f));
        check($sformatf("%s_cnt%0d", tag, ch), 64'(cnt[ch*ACC_W +: ACC_W]), 64'(c));
        check($sformatf("%s_cx%0d", tag, ch), 64'(cx[ch*11 +: 11]), 64'(ecx));
        check($sformatf("%s_cy%0d", tag, ch), 64'(cy[ch*11 +: 11]), 64'(ecy));
        check($sformatf("%s_xmin%0d", tag, ch), 64'(xmin[ch*11 +: 11]), 64'(exl));
        check($sformatf("%s_xmax%0d", tag, ch), 64'(xmax[ch*11 +: 11]), 64'(exh));
        check($sformatf("%s_ymin%0d", tag, ch), 64'(ymin[ch*11 +: 11]), 64'(eyl));
        check($sformatf("%s_ymax%0d", tag, ch), 64'(ymax[ch*11 +: 11]), 64'(eyh));
    endtask

    int n;
    int hl [8] = '{350, 10, 30, 339, 340, 20, 0, 359};

    initial begin
        rst_n = 1'b0; start = 1'b0; valid = 1'b0; fend = 1'b0;
        h = '0; s = 10'd200; v = 10'd200; x = '0; y = '0;
        hmin = '0; hmax = '0; smin = '0; smax = '0; vmin = '0; vmax = '0;
        set_win(0, 100, 140, 100, 255, 100, 255);
        set_win(1, 0, 359, 255, 0, 0, 255);
        #12;
        check("rst_valid", 64'(ovalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check_ch("rst", 0, 0, 0, NF, NF, NF, NF, NF, NF);
        check_ch("rst", 1, 0, 0, NF, NF, NF, NF, NF, NF);
        tick();
        rst_n = 1'b1;
        tick();

        // Square 40x40 on ch0; mid-frame start pulse must not clear the sums.
        h = 10'd120; x = 11'd100; y = 11'd200;
        #1;
        check("t1_match", 64'(match), 64'd1);
        do_start();
        check("t1_busy", 64'(busy), 64'd1);
        send_pix(50, 0, 0, 1'b0);
        for (int yy = 200; yy < 240; yy++)
            for (int xx = 100; xx < 140; xx++) begin
                start = (yy == 220 && xx == 100);
                send_pix(120, xx, yy, (yy == 239 && xx == 139));
                start = 1'b0;
            end
        check("t1_busy_div", 64'(busy), 64'd1);
        wait_valid(n);
        check("t1_latency", 64'(n), 64'd128);
        check("t1_busy_out", 64'(busy), 64'd0);
        check_ch("t1", 0, 1, 1600, 119, 219, 100, 139, 200, 239);
        check_ch("t1", 1, 0, 0, NF, NF, NF, NF, NF, NF);
        tick();
        check("t1_valid_pulse", 64'(ovalid), 64'd0);
        tick(); tick();
        check("t1_hold_cnt", 64'(cnt[0 +: ACC_W]), 64'd1600);

        // Noise threshold boundary: 1024 not found, 1025 found.
        do_start();
        send_square(0, 0, 32, 32, 1'b1);
        wait_valid(n);
        check_ch("t2a", 0, 0, 1024, NF, NF, NF, NF, NF, NF);
        tick();
        do_start();
        send_square(0, 0, 32, 32, 1'b0);
        send_pix(120, 31, 32, 1'b1);
        wait_valid(n);
        check_ch("t2b", 0, 1, 1025, 15, 15, 0, 31, 0, 32);
        tick();

        // Wrapping hue window on ch1.
        set_win(1, 340, 20, 0, 255, 0, 255);
        h = 10'd350; x = 11'd50; y = 11'd50;
        #1;
        check("t3_match_350", 64'(match), 64'd2);
        h = 10'd339;
        #1;
        check("t3_match_339", 64'(match), 64'd0);
        do_start();
        for (int i = 0; i < 8; i++) send_pix(hl[i], 50 + i, 50, (i == 7));
        wait_valid(n);
        check("t3_cnt1", 64'(cnt[ACC_W +: ACC_W]), 64'd6);
        check("t3_found1", 64'(found[1]), 64'd0);
        check("t3_cnt0", 64'(cnt[0 +: ACC_W]), 64'd0);
        tick();

        // Bounds: x=640 / y=480 rejected; matching pixel on frame_end counted.
        h = 10'd120; x = 11'd640; y = 11'd10;
        #1;
        check("t4_match_oob", 64'(match), 64'd0);
        do_start();
        send_square(10, 10, 33, 32, 1'b0);
        send_pix(120, 640, 10, 1'b0);
        send_pix(120, 10, 480, 1'b0);
        send_pix(120, 5, 7, 1'b1);
        wait_valid(n);
        check_ch("t4", 0, 1, 1057, 25, 25, 5, 42, 7, 41);
        check("t4_cnt1", 64'(cnt[ACC_W +: ACC_W]), 64'd0);
        tick();

        // Reset during S_DIV aborts; the next frame is processed normally.
        do_start();
        send_square(100, 200, 40, 40, 1'b1);
        for (int i = 0; i < 50; i++) tick();
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", 64'(ovalid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check_ch("t6r", 0, 0, 0, NF, NF, NF, NF, NF, NF);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (ovalid === 1'b1) n++;
            tick();
        end
        check("t6_no_valid", 64'(n), 64'd0);
        do_start();
        send_square(100, 200, 40, 40, 1'b1);
        wait_valid(n);
        check("t6_latency", 64'(n), 64'd128);
        check_ch("t6", 0, 1, 1600, 119, 219, 100, 139, 200, 239);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
